// File: rtl/mmio_timer_if.sv
// mmio_timer_if: CPU data-bus slot for the countdown timer.
//   A   - word register select (address bits [3:2])
//   WE  - write strobe from the address decoder
//   WD  - write data
//   RD  - read data, combinational from A and register state
//   irq - level interrupt, mirrors STATUS.DONE
// master: the CPU/decoder side. slave: the timer.
interface mmio_timer_if;
  logic [1:0]  A;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        irq;

  modport master (output A, output WE, output WD, input RD, input irq);
  modport slave  (input A, input WE, input WD, output RD, output irq);
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped countdown timer with sticky DONE and optional auto-reload.
//   clk   - system clock, all state changes on the rising edge
//   reset - synchronous, active-high
//   bus   - mmio_timer_if.slave (A, WE, WD in; RD, irq out)
// Register map: 0 CTRL {PSC[15:8], RELOAD[1], EN[0]}, 1 LOAD, 2 COUNT (RO),
// 3 STATUS {BUSY[1], DONE[0] (W1C)}.
// Build option: define TIMER_PRESCALE_EN to store PSC and gate ticks with an
// 8-bit prescale counter; otherwise every cycle is a tick and PSC reads 0.
//
// state | meaning
// IDLE  | EN=0, COUNT holds
// RUN   | EN=1, COUNT decrements on each tick
module mmio_timer #(
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic reset,
  mmio_timer_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic               reload_q;
  logic [CNT_W-1:0]   load_q;
  logic [CNT_W-1:0]   count_q;
  logic               done_q;
  logic               tick;
  logic               ctrl_wr, load_wr, status_wr;
  logic               start, stop, expire;
  logic [31:0]        rd;
  logic [31:0]        unused_wd;

  assign ctrl_wr   = bus.WE && (bus.A == 2'd0);
  assign load_wr   = bus.WE && (bus.A == 2'd1);
  assign status_wr = bus.WE && (bus.A == 2'd3);
  assign start     = (state == IDLE) && ctrl_wr && bus.WD[0];
  assign stop      = (state == RUN) && ctrl_wr && !bus.WD[0];
  // Expiry sets DONE even when a stop write lands in the same cycle.
  assign expire    = (state == RUN) && tick && (count_q == '0);
  assign unused_wd = bus.WD;

`ifdef TIMER_PRESCALE_EN
  logic [7:0] psc_q;
  logic [7:0] psc_cnt;

  // >= rather than == so lowering PSC mid-run cannot strand the counter above it.
  assign tick = (psc_cnt >= psc_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      psc_q   <= '0;
      psc_cnt <= '0;
    end else begin
      if (ctrl_wr) psc_q <= bus.WD[15:8];
      if (start)
        psc_cnt <= '0;
      else if (state == RUN)
        psc_cnt <= tick ? 8'd0 : psc_cnt + 8'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (stop)                     state_nxt = IDLE;
        else if (expire && !reload_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reload_q <= 1'b0;
      load_q   <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      if (ctrl_wr) reload_q <= bus.WD[1];
      if (load_wr) load_q   <= bus.WD[CNT_W-1:0];

      if (start)
        count_q <= load_q;
      else if ((state == RUN) && tick && !stop) begin
        if (count_q != '0) count_q <= count_q - CNT_W'(1);
        else if (reload_q) count_q <= load_q;
      end

      // Set beats a same-cycle write-1-to-clear.
      if (expire)                      done_q <= 1'b1;
      else if (status_wr && bus.WD[0]) done_q <= 1'b0;
    end
  end

  always_comb begin
    rd = '0;
    case (bus.A)
      2'd0: begin
        rd[0] = (state == RUN);
        rd[1] = reload_q;
`ifdef TIMER_PRESCALE_EN
        rd[15:8] = psc_q;
`endif
      end
      2'd1: rd = 32'(load_q);
      2'd2: rd = 32'(count_q);
      2'd3: begin
        rd[0] = done_q;
        rd[1] = (state == RUN);
      end
      default: rd = '0;
    endcase
  end

  assign bus.RD  = rd;
  assign bus.irq = done_q;

endmodule

// File: tb/tb_mmio_timer.sv
module tb_mmio_timer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  mmio_timer_if bus ();

  mmio_timer #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

`ifdef TIMER_PRESCALE_EN
  localparam bit PSC_ON = 1'b1;
`else
  localparam bit PSC_ON = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.A = a; bus.WE = 1'b1; bus.WD = d;
    @(negedge clk);
    bus.WE = 1'b0;
  endtask

  task automatic nop(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rchk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    bus.A = a;
    #1;
    chk(nm, bus.RD, exp);
  endtask

  initial begin
    int L, psc, rl, P, per, N, op;
    logic [31:0] d, exp_cnt;
    bit done_m, busy_m, clr;
    int T;

    bus.A = 2'd0; bus.WE = 1'b0; bus.WD = '0;

    vecs[0]  = '{1'b0, 2'd0, 32'd0,          2'd0, 32'd0, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 32'd0,          2'd1, 32'd0, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd0, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 32'd0,          2'd3, 32'd0, 1'b0};
    vecs[4]  = '{1'b1, 2'd1, 32'd5,          2'd1, 32'd5, 1'b0};
    vecs[5]  = '{1'b1, 2'd0, 32'd1,          2'd2, 32'd5, 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd4, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd3, 1'b0};
    vecs[8]  = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd2, 1'b0};
    vecs[9]  = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd1, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd0, 1'b0};
    vecs[11] = '{1'b0, 2'd0, 32'd0,          2'd3, 32'd1, 1'b1};
    vecs[12] = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd0, 1'b1};
    vecs[13] = '{1'b1, 2'd3, 32'hFFFF_FFFE,  2'd3, 32'd1, 1'b1};
    vecs[14] = '{1'b1, 2'd2, 32'd99,         2'd2, 32'd0, 1'b1};
    vecs[15] = '{1'b1, 2'd3, 32'd1,          2'd3, 32'd0, 1'b0};
    vecs[16] = '{1'b1, 2'd0, 32'hFFFF_0302,  2'd0, PSC_ON ? 32'h0302 : 32'h0002, 1'b0};
    vecs[17] = '{1'b1, 2'd0, 32'd0,          2'd0, 32'd0, 1'b0};

    // Values must already be zero while reset is held.
    @(posedge clk); #1;
    for (int a = 0; a < 4; a++) rchk($sformatf("in_reset_rd%0d", a), 2'(a), 32'd0);
    chk("in_reset_irq", 32'(bus.irq), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      bus.A = vecs[i].wa; bus.WE = vecs[i].we; bus.WD = vecs[i].wd;
      @(negedge clk);
      bus.WE = 1'b0;
      rchk($sformatf("vec%0d_rd", i), vecs[i].ra, vecs[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), 32'(bus.irq), 32'(vecs[i].exp_irq));
    end

    // Auto-reload, W1C, and W1C colliding with expiry.
    wr(2'd1, 32'd3); wr(2'd0, 32'd3);
    rchk("ar_k_cnt", 2'd2, 32'd3);
    nop(3);
    rchk("ar_k3_cnt", 2'd2, 32'd0);
    rchk("ar_k3_st", 2'd3, 32'd2);
    nop(1);
    rchk("ar_k4_st", 2'd3, 32'd3);
    rchk("ar_k4_cnt", 2'd2, 32'd3);
    wr(2'd3, 32'd1);
    rchk("ar_clr_st", 2'd3, 32'd2);
    nop(2);
    rchk("ar_k7_st", 2'd3, 32'd2);
    nop(1);
    rchk("ar_k8_st", 2'd3, 32'd3);
    nop(3);
    rchk("ar_k11_cnt", 2'd2, 32'd0);
    wr(2'd3, 32'd1);
    rchk("w1c_vs_set_st", 2'd3, 32'd3);
    rchk("w1c_vs_set_cnt", 2'd2, 32'd3);
    wr(2'd0, 32'd0); wr(2'd3, 32'd1);
    rchk("ar_cleanup_st", 2'd3, 32'd0);

    // Stop mid-count holds COUNT.
    wr(2'd1, 32'd5); wr(2'd0, 32'd1);
    nop(3);
    rchk("stop_pre_cnt", 2'd2, 32'd2);
    wr(2'd0, 32'd0);
    rchk("stop_cnt", 2'd2, 32'd2);
    rchk("stop_st", 2'd3, 32'd0);
    nop(10);
    rchk("stop_hold_cnt", 2'd2, 32'd2);
    rchk("stop_hold_st", 2'd3, 32'd0);

    // Stop colliding with expiry: no reload, DONE still set.
    wr(2'd1, 32'd1); wr(2'd0, 32'd3);
    nop(1);
    rchk("xstop_pre_cnt", 2'd2, 32'd0);
    wr(2'd0, 32'd0);
    rchk("xstop_st", 2'd3, 32'd1);
    rchk("xstop_cnt", 2'd2, 32'd0);
    nop(3);
    rchk("xstop_hold_cnt", 2'd2, 32'd0);
    wr(2'd3, 32'd1);

    // Prescale.
    wr(2'd1, 32'd2); wr(2'd0, 32'h0301);
    rchk("psc_ctrl", 2'd0, PSC_ON ? 32'h0301 : 32'h0001);
    nop(PSC_ON ? 11 : 2);
    rchk("psc_before_done", 2'd3, 32'd2);
    nop(1);
    rchk("psc_done", 2'd3, 32'd1);
    wr(2'd3, 32'd1);

    // Reset mid-count.
    wr(2'd1, 32'd10); wr(2'd0, 32'd1);
    nop(3);
    rchk("rst_pre_cnt", 2'd2, 32'd7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) rchk($sformatf("rst_mid_rd%0d", a), 2'(a), 32'd0);
    chk("rst_mid_irq", 32'(bus.irq), 32'd0);
    nop(20);
    rchk("rst_later_st", 2'd3, 32'd0);
    chk("rst_later_irq", 32'(bus.irq), 32'd0);

    // Randomized runs against an arithmetic model of ticks and expiries.
    for (int r = 0; r < 8; r++) begin
      L   = $urandom_range(0, 6);
      psc = $urandom_range(0, 3);
      rl  = $urandom_range(0, 1);
      P   = PSC_ON ? psc + 1 : 1;
      per = (L + 1) * P;
      N   = per * 3 + 3;
      wr(2'd0, 32'd0); wr(2'd3, 32'd1); wr(2'd1, 32'(L));
      wr(2'd0, 32'((psc << 8) | (rl << 1) | 1));
      done_m = 1'b0;
      for (int n = 0; n <= N; n++) begin
        T = n / P;
        if (rl != 0) exp_cnt = 32'(L - (T % (L + 1)));
        else         exp_cnt = (T <= L) ? 32'(L - T) : 32'd0;
        busy_m = (rl != 0) || (n < per);
        rchk($sformatf("rnd%0d_n%0d_cnt", r, n), 2'd2, exp_cnt);
        rchk($sformatf("rnd%0d_n%0d_st", r, n), 2'd3, {30'd0, busy_m, done_m});
        if (n == N) break;
        op = $urandom_range(0, 3);
        d  = $urandom;
        clr = 1'b0;
        if (op == 1) begin
          bus.A = 2'd3; bus.WE = 1'b1; bus.WD = d; clr = d[0];
        end else if (op == 2) begin
          bus.A = 2'd2; bus.WE = 1'b1; bus.WD = d;
        end
        @(negedge clk);
        bus.WE = 1'b0;
        if (clr) done_m = 1'b0;
        if (((n + 1) % per == 0) && (rl != 0 || (n + 1) == per)) done_m = 1'b1;
      end
    end
    wr(2'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
